// File: rtl/router_pkt_fifo.sv
// Packet-aware FIFO for one router output channel: stores {sop, data} per entry and
// frames reads with registered valid/SOP/EOP flags plus a sticky framing-error flag.
module router_pkt_fifo #(
  parameter int WIDTH     = 8,
  parameter int DEPTH     = 16,
  parameter int AF_THRESH = DEPTH - 2,
  parameter int LEN_LSB   = 2
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic                     soft_reset,
  input  logic                     wr_en,
  input  logic                     sop_in,
  input  logic [WIDTH-1:0]         data_in,
  input  logic                     rd_en,
  output logic [WIDTH-1:0]         data_out,
  output logic                     rd_valid,
  output logic                     rd_sop,
  output logic                     rd_eop,
  output logic                     empty,
  output logic                     full,
  output logic                     almost_full,
  output logic [$clog2(DEPTH):0]   fill_level,
  output logic                     pkt_err
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = WIDTH - LEN_LSB;
  localparam int RW = LW + 1;

  localparam logic [AW-1:0] PTR_ONE  = {{(AW-1){1'b0}}, 1'b1};
  localparam logic [AW:0]   CNT_ONE  = {{AW{1'b0}}, 1'b1};
  localparam logic [RW-1:0] REM_ONE  = {{(RW-1){1'b0}}, 1'b1};
  localparam logic [AW:0]   FULL_CNT = DEPTH[AW:0];
  localparam logic [AW:0]   AF_CNT   = AF_THRESH[AW:0];

  logic [WIDTH:0]    mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic [AW:0]       count;
  logic [RW-1:0]     remaining;
  logic              wr_ok;
  logic              rd_ok;
  logic [WIDTH:0]    rd_word;
  logic              rd_word_sop;
  logic [WIDTH-1:0]  rd_word_data;
  logic [LW-1:0]     rd_len;

  assign empty       = (count == '0);
  assign full        = (count == FULL_CNT);
  assign almost_full = (count >= AF_CNT);
  assign fill_level  = count;

  assign wr_ok = wr_en && !full;
  assign rd_ok = rd_en && !empty;

  assign rd_word      = mem[rd_ptr];
  assign rd_word_sop  = rd_word[WIDTH];
  assign rd_word_data = rd_word[WIDTH-1:0];
  assign rd_len       = rd_word[WIDTH-1:LEN_LSB];

  // Storage array has no reset; the pointers alone decide which entries are live.
  always_ff @(posedge clk) begin
    if (wr_ok && !soft_reset)
      mem[wr_ptr] <= {sop_in, data_in};
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (soft_reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_ok)
        wr_ptr <= wr_ptr + PTR_ONE;
      if (rd_ok)
        rd_ptr <= rd_ptr + PTR_ONE;
      case ({wr_ok, rd_ok})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

  // Header reads load payload length + 1 so the parity byte is the one that hits zero.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      data_out  <= '0;
      rd_valid  <= 1'b0;
      rd_sop    <= 1'b0;
      rd_eop    <= 1'b0;
      pkt_err   <= 1'b0;
      remaining <= '0;
    end else if (soft_reset) begin
      data_out  <= '0;
      rd_valid  <= 1'b0;
      rd_sop    <= 1'b0;
      rd_eop    <= 1'b0;
      pkt_err   <= 1'b0;
      remaining <= '0;
    end else begin
      rd_valid <= rd_ok;
      rd_sop   <= 1'b0;
      rd_eop   <= 1'b0;
      if (rd_ok) begin
        data_out <= rd_word_data;
        if (rd_word_sop) begin
          rd_sop    <= 1'b1;
          remaining <= {1'b0, rd_len} + REM_ONE;
          if (remaining != '0)
            pkt_err <= 1'b1;
        end else if (remaining != '0) begin
          remaining <= remaining - REM_ONE;
          rd_eop    <= (remaining == REM_ONE);
        end else begin
          pkt_err <= 1'b1;
        end
      end
    end
  end

endmodule
